// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: inspects the reorder-buffer head each cycle and
// retires it with its side effect (RF write, store handshake, flush or halt).
module commit_ctrl #(
    parameter int RoB_WIDTH    = 3,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [RoB_WIDTH-1:0] head_index,
    input  logic [1:0]           head_type,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_value,
    input  logic                 head_mispredict,
    input  logic [31:0]          head_target,
    output logic                 head_pop,
    output logic                 rf_update_en,
    output logic [4:0]           rf_update_reg,
    output logic [RoB_WIDTH-1:0] rf_update_index,
    output logic [31:0]          rf_update_data,
    output logic                 store_req,
    input  logic                 store_ack,
    output logic                 flush_signal,
    output logic [31:0]          flush_pc,
    output logic                 halted,
    output logic [31:0]          commit_count
);

    localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2,
        HALTED     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_STORE  = 2'd1,
        T_BRANCH = 2'd2,
        T_HALT   = 2'd3
    } htype_t;

    state_t        state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [31:0]   flush_pc_q, flush_pc_d;
    logic          halted_q, halted_d;
    logic [31:0]   commit_q, commit_d;

    logic pop_c;
    logic wr_c;
    logic store_req_c;
    logic go;

    assign go = rdy_in && head_valid && head_ready;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        flush_pc_d  = flush_pc_q;
        halted_d    = halted_q;
        pop_c       = 1'b0;
        wr_c        = 1'b0;
        store_req_c = 1'b0;

        unique case (state_q)
            RUN: begin
                if (go) begin
                    unique case (htype_t'(head_type))
                        T_REG: begin
                            pop_c = 1'b1;
                            wr_c  = 1'b1;
                        end
                        T_BRANCH: begin
                            pop_c = 1'b1;
                            wr_c  = 1'b1;
                            if (head_mispredict) begin
                                state_d    = FLUSH;
                                fcnt_d     = CW'(FLUSH_CYCLES);
                                flush_pc_d = head_target;
                            end
                        end
                        // The store pops only once the memory unit acknowledges it.
                        T_STORE: state_d = STORE_WAIT;
                        T_HALT: begin
                            pop_c    = 1'b1;
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            STORE_WAIT: begin
                store_req_c = 1'b1;
                if (rdy_in && store_ack) begin
                    pop_c   = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (rdy_in) begin
                    fcnt_d = fcnt_q - CW'(1);
                    if (fcnt_q <= CW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase

        commit_d = commit_q + 32'(pop_c);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            flush_pc_q <= '0;
            halted_q   <= 1'b0;
            commit_q   <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            flush_pc_q <= flush_pc_d;
            halted_q   <= halted_d;
            commit_q   <= commit_d;
        end
    end

    // Combinational outputs are gated by reset so everything reads 0 while it is held.
    always_comb begin
        head_pop        = pop_c && rst_in;
        rf_update_en    = wr_c && rst_in && (head_rd != 5'd0);
        rf_update_reg   = '0;
        rf_update_index = '0;
        rf_update_data  = '0;
        if (rf_update_en) begin
            rf_update_reg   = head_rd;
            rf_update_index = head_index;
            rf_update_data  = head_value;
        end
        store_req = store_req_c && rst_in;
    end

    assign flush_signal = (state_q == FLUSH);
    assign flush_pc     = flush_pc_q;
    assign halted       = halted_q;
    assign commit_count = commit_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: a per-cycle behavioural model plus literal spot checks.
module tb_commit_ctrl;

    localparam int RW = 3;
    localparam int FC = 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          head_valid;
    logic          head_ready;
    logic [RW-1:0] head_index;
    logic [1:0]    head_type;
    logic [4:0]    head_rd;
    logic [31:0]   head_value;
    logic          head_mispredict;
    logic [31:0]   head_target;
    logic          head_pop;
    logic          rf_update_en;
    logic [4:0]    rf_update_reg;
    logic [RW-1:0] rf_update_index;
    logic [31:0]   rf_update_data;
    logic          store_req;
    logic          store_ack;
    logic          flush_signal;
    logic [31:0]   flush_pc;
    logic          halted;
    logic [31:0]   commit_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    commit_ctrl #(.RoB_WIDTH(RW), .FLUSH_CYCLES(FC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .head_valid(head_valid), .head_ready(head_ready), .head_index(head_index),
        .head_type(head_type), .head_rd(head_rd), .head_value(head_value),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .head_pop(head_pop), .rf_update_en(rf_update_en), .rf_update_reg(rf_update_reg),
        .rf_update_index(rf_update_index), .rf_update_data(rf_update_data),
        .store_req(store_req), .store_ack(store_ack), .flush_signal(flush_signal),
        .flush_pc(flush_pc), .halted(halted), .commit_count(commit_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the sequencer is currently doing, in architectural terms.
    logic        m_store_pending = 1'b0;
    int unsigned m_flush_left    = 0;
    logic        m_halted        = 1'b0;
    logic [31:0] m_flush_pc      = '0;
    logic [31:0] m_count         = '0;
    logic        e_pop;

    always @(negedge clk_in) begin
        logic        e_en;
        logic [4:0]  e_reg;
        logic [RW-1:0] e_idx;
        logic [31:0] e_data;
        e_pop = 1'b0;
        e_en = 1'b0; e_reg = '0; e_idx = '0; e_data = '0;
        if (!rst_in) begin
            check("rst_pop", 32'(head_pop), 0);
            check("rst_rf_en", 32'(rf_update_en), 0);
            check("rst_store_req", 32'(store_req), 0);
            check("rst_flush", 32'(flush_signal), 0);
            check("rst_flush_pc", flush_pc, 0);
            check("rst_halted", 32'(halted), 0);
            check("rst_count", commit_count, 0);
        end else begin
            if (rdy_in) begin
                if (m_store_pending) begin
                    e_pop = store_ack;
                end else if (m_flush_left == 0 && !m_halted && head_valid && head_ready) begin
                    e_pop = (head_type != 2'd1);
                    if ((head_type == 2'd0 || head_type == 2'd2) && head_rd != 5'd0) begin
                        e_en = 1'b1; e_reg = head_rd; e_idx = head_index; e_data = head_value;
                    end
                end
            end
            check("pop", 32'(head_pop), 32'(e_pop));
            check("rf_en", 32'(rf_update_en), 32'(e_en));
            check("rf_reg", 32'(rf_update_reg), 32'(e_reg));
            check("rf_idx", 32'(rf_update_index), 32'(e_idx));
            check("rf_data", rf_update_data, e_data);
            check("store_req", 32'(store_req), 32'(m_store_pending));
            check("flush", 32'(flush_signal), 32'(m_flush_left != 0));
            check("flush_pc", flush_pc, m_flush_pc);
            check("halted", 32'(halted), 32'(m_halted));
            check("count", commit_count, m_count);
        end
    end

    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_store_pending = 1'b0; m_flush_left = 0; m_halted = 1'b0;
            m_flush_pc = '0; m_count = '0;
        end else if (rdy_in) begin
            if (e_pop) m_count = m_count + 1;
            if (m_store_pending) begin
                if (store_ack) m_store_pending = 1'b0;
            end else if (m_flush_left != 0) begin
                m_flush_left = m_flush_left - 1;
            end else if (!m_halted && head_valid && head_ready) begin
                case (head_type)
                    2'd1: m_store_pending = 1'b1;
                    2'd2: if (head_mispredict) begin
                              m_flush_left = FC;
                              m_flush_pc = head_target;
                          end
                    2'd3: m_halted = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic head(input logic [1:0] t, input logic [4:0] rd, input logic [RW-1:0] idx,
                        input logic [31:0] val, input logic misp, input logic [31:0] tgt);
        head_valid = 1'b1; head_ready = 1'b1; head_type = t; head_rd = rd;
        head_index = idx; head_value = val; head_mispredict = misp; head_target = tgt;
    endtask

    task automatic no_head();
        head_valid = 1'b0; head_ready = 1'b0; head_type = '0; head_rd = '0;
        head_index = '0; head_value = '0; head_mispredict = 1'b0; head_target = '0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; store_ack = 1'b0;
        no_head();
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // 1: REG retire with RF write
        head(2'd0, 5'd5, 3'd2, 32'h1234, 1'b0, 0);
        #2;
        check("t1_pop", 32'(head_pop), 1);
        check("t1_en", 32'(rf_update_en), 1);
        check("t1_reg", 32'(rf_update_reg), 5);
        check("t1_idx", 32'(rf_update_index), 2);
        check("t1_data", rf_update_data, 32'h1234);
        tick();
        check("t1_count", commit_count, 1);

        // 2: rd=0 pops without write; not-ready head is not popped
        head(2'd0, 5'd0, 3'd3, 32'hdead, 1'b0, 0);
        #2;
        check("t2_pop", 32'(head_pop), 1);
        check("t2_en", 32'(rf_update_en), 0);
        tick();
        check("t2_count", commit_count, 2);
        head_ready = 1'b0;
        #2;
        check("t2_nopop", 32'(head_pop), 0);
        tick();

        // 3: store with ack delayed 3 cycles
        head(2'd1, 5'd7, 3'd4, 32'h99, 1'b0, 0);
        #2;
        check("t3_first_pop", 32'(head_pop), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_req", 32'(store_req), 1);
            check("t3_wait_pop", 32'(head_pop), 0);
            tick();
        end
        store_ack = 1'b1;
        #2;
        check("t3_req_ack", 32'(store_req), 1);
        check("t3_ack_pop", 32'(head_pop), 1);
        check("t3_ack_en", 32'(rf_update_en), 0);
        tick();
        store_ack = 1'b0;
        no_head();
        #2;
        check("t3_req_off", 32'(store_req), 0);
        check("t3_count", commit_count, 3);
        tick();

        // 4: mispredicted branch, then flush, then resume
        head(2'd2, 5'd1, 3'd5, 32'h104, 1'b1, 32'h200);
        #2;
        check("t4_pop", 32'(head_pop), 1);
        check("t4_en", 32'(rf_update_en), 1);
        check("t4_reg", 32'(rf_update_reg), 1);
        check("t4_data", rf_update_data, 32'h104);
        tick();
        head(2'd0, 5'd3, 3'd6, 32'h55, 1'b0, 0);
        #2;
        check("t4_flush", 32'(flush_signal), 1);
        check("t4_flush_pc", flush_pc, 32'h200);
        check("t4_flush_pop", 32'(head_pop), 0);
        tick();
        check("t4_flush_off", 32'(flush_signal), 0);
        check("t4_resume_pop", 32'(head_pop), 1);
        tick();
        check("t4_count", commit_count, 5);
        head(2'd2, 5'd2, 3'd7, 32'h108, 1'b0, 32'h300);
        tick();
        check("t4_no_flush", 32'(flush_signal), 0);
        check("t4_pc_held", flush_pc, 32'h200);

        // 5: rdy_in low freezes retirement
        head(2'd0, 5'd9, 3'd1, 32'haa, 1'b0, 0);
        rdy_in = 1'b0;
        #2;
        check("t5_pause_pop", 32'(head_pop), 0);
        check("t5_pause_en", 32'(rf_update_en), 0);
        tick();
        check("t5_pause_count", commit_count, 6);
        rdy_in = 1'b1;
        #2;
        check("t5_pop", 32'(head_pop), 1);
        tick();
        check("t5_count", commit_count, 7);

        // 6: halt is sticky; reset mid store wait
        head(2'd3, 5'd4, 3'd2, 32'h0, 1'b0, 0);
        #2;
        check("t6_pop", 32'(head_pop), 1);
        check("t6_en", 32'(rf_update_en), 0);
        tick();
        check("t6_halted", 32'(halted), 1);
        head(2'd0, 5'd6, 3'd3, 32'h77, 1'b0, 0);
        tick(); tick();
        check("t6_still_halted", 32'(halted), 1);
        check("t6_count", commit_count, 8);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        check("t6_after_rst_count", commit_count, 1);
        head(2'd1, 5'd0, 3'd0, 32'h0, 1'b0, 0);
        tick();
        check("t6_store_req", 32'(store_req), 1);
        rst_in = 1'b0;
        #1;
        check("t6_req_drop", 32'(store_req), 0);
        check("t6_rst_count", commit_count, 0);
        check("t6_rst_halted", 32'(halted), 0);
        tick();
        rst_in = 1'b1;
        no_head();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
In-order retirement sequencer between the reorder buffer head and the register file. Each cycle it inspects the RoB head entry and decides whether to retire it, and which side effect goes with the retirement:
- a register write on the RF update port,
- a store handshake with the memory unit,
- a pipeline flush on a mispredicted branch,
- a halt.
It is the only source of the RF update port and the global flush signal.

Parameters:
RoB_WIDTH, 3, log2 of RoB depth; index width.
FLUSH_CYCLES, 1, cycles flush_signal is held (must be >=1).

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous reset, active-low
rdy_in  in  1  global ready; 0 = pause
head_valid  in  1  RoB head entry exists
head_ready  in  1  head result computed
head_index  in  RoB_WIDTH  RoB index of head
head_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=HALT
head_rd  in  5  destination register
head_value  in  32  result / link value
head_mispredict  in  1  branch mispredicted
head_target  in  32  correct PC for mispredict
head_pop  out  1  RoB advances head at this edge
rf_update_en  out  1  RF write enable
rf_update_reg  out  5  RF write register
rf_update_index  out  RoB_WIDTH  RoB index to clear RF dependency
rf_update_data  out  32  RF write data
store_req  out  1  store commit request (level)
store_ack  in  1  memory unit accepted store
flush_signal  out  1  global flush
flush_pc  out  32  redirect PC
halted  out  1  sticky halt flag
commit_count  out  32  retired-instruction count

Behaviour:
- States: RUN, STORE_WAIT, FLUSH, HALTED.
- Reset (async, rst_in=0): state=RUN, flush counter=0, commit_count=0, flush_pc=0, halted=0. All outputs read 0 while reset is asserted. Reset during STORE_WAIT or FLUSH drops store_req/flush_signal immediately.
- rdy_in=0: state, counters and registers frozen. head_pop=0 and rf_update_en=0. store_req/flush_signal keep their state-derived values.
- head_pop, rf_update_* and store_req are combinational from state and head inputs; the RoB and RF sample them on the same edge. flush_signal, flush_pc and halted are registered.
- Define "go" = state==RUN && rdy_in && head_valid && head_ready.
- RUN, go, type REG: head_pop=1; rf_update_en=(head_rd!=0); reg/index/data = head_rd/head_index/head_value. Stay RUN.
- RUN, go, type BRANCH: head_pop=1; RF write as for REG (link value).
  - If head_mispredict: next state FLUSH, flush_pc<=head_target, flush counter<=FLUSH_CYCLES.
  - Otherwise stay RUN.
- RUN, go, type STORE: head_pop=0, no RF write; next state STORE_WAIT.
- RUN, go, type HALT: head_pop=1, no RF write; next state HALTED, halted<=1.
- STORE_WAIT: store_req=1. When store_ack=1 (and rdy_in): head_pop=1 that cycle, next state RUN. store_ack while in RUN is ignored.
- FLUSH: flush_signal=1. Counter decrements each cycle; returns to RUN after FLUSH_CYCLES cycles. The head is ignored while in FLUSH, so no pop and no RF write.
- HALTED: terminal until reset. No pops, no RF writes, halted=1.
- commit_count increments by 1 (mod 2^32) on every head_pop=1 edge.
- At most one retirement per cycle.
- Outputs when the head is not retiring: rf_update_* fields are don't-care when rf_update_en=0, but must be driven 0 to keep waveforms clean.

Test Plan:
1. Reset released; head REG, rd=5, index=2, value=0x1234, ready=1 for one cycle -> same cycle head_pop=1, rf_update_en=1, reg=5, idx=2, data=0x1234; commit_count=1 after the edge.
2. head REG rd=0 -> head_pop=1, rf_update_en=0, count increments. head_ready=0 -> no pop.
3. Head STORE; store_ack delayed 3 cycles -> store_req=1 for 4 cycles; head_pop=1 only in the ack cycle; back in RUN next cycle; no RF write.
4. BRANCH mispredict, rd=1, value=0x104, target=0x200, FLUSH_CYCLES=1 -> pop plus RF write x1=0x104; next cycle flush_signal=1, flush_pc=0x200, no pop even with a valid ready head; following cycle RUN resumes commits.
5. rdy_in=0 while a ready REG head is presented -> no pop/update, count unchanged; rdy_in=1 -> retires.
6. HALT head -> pop, halted=1 sticky; later ready heads are not popped. Assert rst_in=0 mid-STORE_WAIT -> store_req drops immediately, count=0, halted=0.
